// File: rtl/bp_history_table.sv
// Direct-mapped branch history table + target buffer feeding the fetch PC select.
// Latency: lookup result registered one cycle after PC_in; updates land on the same edge.
// Backpressure: stall_in freezes the lookup outputs; execute updates are never blocked.
module bp_history_table #(
    parameter int         PC_W     = 16,
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall_in,
    input  logic [PC_W-1:0] PC_in,
    output logic            H_BP_out,
    output logic [PC_W-1:0] BTA_out,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W;

    logic             valid_q [DEPTH];
    logic             valid_d [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic [TAG_W-1:0] tag_d   [DEPTH];
    logic [PC_W-1:0]  tgt_q   [DEPTH];
    logic [PC_W-1:0]  tgt_d   [DEPTH];
    logic [1:0]       ctr_q   [DEPTH];
    logic [1:0]       ctr_d   [DEPTH];

    logic             h_bp_q, h_bp_d;
    logic [PC_W-1:0]  bta_q, bta_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;

    assign lk_idx = PC_in[IDX_W-1:0];
    assign lk_tag = PC_in[PC_W-1:IDX_W];
    assign up_idx = upd_pc[IDX_W-1:0];
    assign up_tag = upd_pc[PC_W-1:IDX_W];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign H_BP_out = h_bp_q;
    assign BTA_out  = bta_q;

    // Lookup reads the registered table, so a same-cycle update is not seen (read-before-write).
    always_comb begin
        h_bp_d = h_bp_q;
        bta_d  = bta_q;
        if (!stall_in) begin
            if (lk_hit) begin
                h_bp_d = ctr_q[lk_idx][1];
                bta_d  = tgt_q[lk_idx];
            end else begin
                h_bp_d = 1'b0;
                bta_d  = '0;
            end
        end
    end

    // Resolution update: train on hit, allocate only taken branches with a usable target.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (upd_en) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    end
                    // A zero target would read back as "no branch", so it is never stored.
                    if (upd_target != '0) begin
                        tgt_d[up_idx] = upd_target;
                    end
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                end
            end else if (upd_taken && (upd_target != '0)) begin
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = upd_target;
                ctr_d[up_idx]   = 2'b10;
            end
        end
    end

    // Table and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= CTR_INIT;
            end
            h_bp_q <= 1'b0;
            bta_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
            h_bp_q  <= h_bp_d;
            bta_q   <= bta_d;
        end
    end

endmodule

// File: doc/bp_history_table.md
Name: bp_history_table

Overview:
- Branch history table plus branch target buffer that produces the predictor outputs consumed by the fetch-stage PC select controller.
- For each fetch PC it returns a registered prediction bit and a branch target address. A zero target means "no branch known here".
- Resolved branches from execute update 2-bit saturating counters and stored targets.

Parameters:
- PC_W, 16, width of PC and target addresses.
- IDX_W, 4, index bits; table depth = 2**IDX_W entries, direct-mapped.
- CTR_INIT, 2'b01, counter value loaded at reset (weakly not-taken).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- stall_in  input  1  fetch stall; when 1, lookup outputs hold their value.
- PC_in  input  PC_W  fetch PC to look up.
- H_BP_out  output  1  registered prediction: 1 = predict taken.
- BTA_out  output  PC_W  registered predicted target; 16'b0 on miss.
- upd_en  input  1  execute-stage branch resolution valid.
- upd_pc  input  PC_W  PC of resolved branch.
- upd_taken  input  1  actual outcome.
- upd_target  input  PC_W  actual target address.

Behaviour:
- Entry fields: valid (1), tag (PC_W-IDX_W), target (PC_W), ctr (2).
  - index = PC[IDX_W-1:0]; tag = PC[PC_W-1:IDX_W].
- Reset (reset=0, async):
  - All valid=0, all ctr=CTR_INIT; targets and tags cleared.
  - H_BP_out=0, BTA_out=0, held until the first posedge after reset deasserts.
- Lookup, 1-cycle latency:
  - At posedge with stall_in=0: hit = valid[idx] && tag[idx]==PC_in tag.
  - On hit: BTA_out<=target[idx], H_BP_out<=ctr[idx][1].
  - On miss: BTA_out<=0, H_BP_out<=0.
  - stall_in=1: outputs hold and table reads are ignored. Updates still proceed.
- Update, on posedge with upd_en=1; idx/tag taken from upd_pc:
  - Tag hit:
    - Taken: ctr increments, saturating at 2'b11, and target<=upd_target.
    - Not taken: ctr decrements, saturating at 2'b00; target unchanged.
  - Miss with upd_taken=1 and upd_target!=0: allocate/replace the entry. valid=1, tag written, target=upd_target, ctr=2'b10.
  - Miss with upd_taken=0: no change; not-taken branches are never allocated.
  - Taken with upd_target==0: target is never written to 0. Counter still updates on a hit; no allocation on a miss.
- Simultaneous lookup and update to the same index in one cycle:
  - Read-before-write: the lookup returns the pre-update entry.
  - The updated state is visible to a lookup in the next cycle.
- Entries are never invalidated except by reset. An entry evicted by an allocation from a different tag is lost.
- Invariant: BTA_out==0 implies H_BP_out==0.

Test Plan:
- Reset then PC_in=16'h0040, no updates -> next cycle H_BP_out=0, BTA_out=16'h0000. Assert reset mid-run -> outputs 0 immediately, without waiting for a clock.
- Update upd_pc=16'h0040, taken, target 16'h0100; then lookup 16'h0040 -> one cycle later H_BP_out=1 (ctr=10), BTA_out=16'h0100.
- Saturation:
  - Three more taken updates on 16'h0040 -> ctr=11. Three not-taken -> ctr=00; lookup gives H_BP_out=0, BTA_out=16'h0100 (hit, predicted not taken).
  - Four further not-taken updates -> ctr stays 00 (no wrap to 11).
- Aliasing: allocate 16'h0040, then taken update 16'h0050, target 16'h0200 (same index, different tag) -> lookup 16'h0040 misses (0/0); lookup 16'h0050 gives 1/16'h0200.
- Same-cycle conflict: entry ctr=01, upd_en taken on 16'h0040 in the same cycle as lookup of 16'h0040 -> that lookup gives H_BP_out=0 (old ctr); next-cycle lookup gives 1.
- stall_in=1 while PC_in changes to 16'h0080 -> outputs hold the previous values. Not-taken update on a missing PC -> no allocation, later lookup misses. Taken update with target 0 on a missing PC -> no allocation.
